// File: rtl/alu_exec_if.sv
// Operand/result bundle between the EX-stage controller and alu_exec_unit.
// The controller drives the master side; the execution unit is the slave.
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [2:0]       Operacioni;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Zero;

  modport master (
    output Start, Operacioni, A, B,
    input  Busy, Done, Result, Zero
  );

  modport slave (
    input  Start, Operacioni, A, B,
    output Busy, Done, Result, Zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU; MUL is an iterative shift-add that holds Busy.
// Define ALU_EXEC_FAST_MUL_EN for a single-cycle MUL with no Busy/FSM.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input logic       Clock,
  input logic       Reset,
  alu_exec_if.slave bus
);
  localparam int          SW    = $clog2(WIDTH);
  localparam logic [SW:0] WBITS = (SW+1)'(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [SW-1:0]    shAmt;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  assign shAmt = bus.B[SW-1:0];

  // A left shift by WIDTH yields zero, so amount 0 rotates to A unchanged.
  always_comb begin
    aluRes = '0;
    case (bus.Operacioni)
      OP_AND: aluRes = bus.A & bus.B;
      OP_OR:  aluRes = bus.A | bus.B;
      OP_XOR: aluRes = bus.A ^ bus.B;
      OP_ADD: aluRes = bus.A + bus.B;
      OP_SUB: aluRes = bus.A - bus.B;
      OP_ROR: aluRes = (bus.A >> shAmt) | (bus.A << (WBITS - {1'b0, shAmt}));
      OP_SLL: aluRes = bus.A << shAmt;
      OP_MUL: begin
`ifdef ALU_EXEC_FAST_MUL_EN
        aluRes = bus.A * bus.B;
`else
        aluRes = '0;
`endif
      end
    endcase
  end

`ifdef ALU_EXEC_FAST_MUL_EN
  assign bus.Busy = 1'b0;

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (bus.Start) begin
      result_d = aluRes;
      zero_d   = (aluRes == '0);
      done_d   = 1'b1;
    end
  end
`else
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  assign bus.Busy = (state_q == S_MUL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Operacioni == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = bus.A;
            mplier_d = bus.B;
            cnt_d    = WBITS;
            state_d  = S_MUL;
          end else begin
            result_d = aluRes;
            zero_d   = (aluRes == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        // Bits shifted out of the multiplicand only affect the discarded upper product.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == (SW+1)'(1)) begin
          result_d = acc_d;
          zero_d   = (acc_d == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.Zero   = zero_q;
  assign bus.Done   = done_q;
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered 16-bit execution unit that consumes the 3-bit `Operacioni` code driven by ALU control. It performs the selected operation on two operands and returns a registered `Result` with a `Done` pulse. All operations complete in one cycle except MUL, which by default is an iterative shift-add sequence that holds `Busy` so the datapath controller stalls. It sits in the EX stage between the register-file read ports and the write-back mux.

## Interface
- `WIDTH`, 16, operand/result width; shift amount is `B[$clog2(WIDTH)-1:0]`
- `Clock`  in  1  single clock, rising edge
- `Reset`  in  1  synchronous, active-high
- `Start`  in  1  request; sampled only when the unit is in IDLE
- `Operacioni`  in  3  operation code, captured with `Start`
- `A`  in  WIDTH  operand A, captured with `Start`
- `B`  in  WIDTH  operand B (or shift amount), captured with `Start`
- `Busy`  out  1  high while a multi-cycle MUL is in progress
- `Done`  out  1  one-cycle pulse when `Result` is updated
- `Result`  out  WIDTH  registered result; held until the next completion
- `Zero`  out  1  registered, equals (`Result` == 0)

## Operation
- Codes:
  - 000 AND; 001 OR; 011 XOR
  - 010 ADD, mod 2^WIDTH, carry discarded
  - 110 SUB, A−B mod 2^WIDTH
  - 101 ROR, A rotated right by `B[3:0]`
  - 100 SLL, A << `B[3:0]`, zero fill
  - 111 MUL, low WIDTH bits of A×B (unsigned)
  - All 8 codes are defined; there is no default/illegal path.
- FSM states:
  - IDLE: on `Start`, latch operands and code.
    - Non-MUL: write `Result`/`Zero`, pulse `Done`, stay in IDLE.
    - MUL: clear accumulator, load counter = WIDTH, go to MUL.
  - MUL: each edge, if multiplier LSB = 1 then acc += multiplicand; shift multiplicand left and multiplier right; decrement counter. When the counter reaches 0, write `Result`/`Zero`, pulse `Done`, return to IDLE.
- `Start` while in MUL (`Busy` = 1) is ignored; no queuing.
- Shift amount 0 for ROR/SLL returns A unchanged.

## Timing
- Reset values: `Busy` = 0, `Done` = 0, `Result` = 0, `Zero` = 1; FSM in IDLE; counter = 0.
- Let E0 be the edge sampling `Start` = 1 in IDLE.
- Non-MUL: `Result`, `Zero` and `Done` = 1 are valid after E0; `Done` falls after E1 unless a new `Start` was accepted at E1. Back-to-back `Start` every cycle gives a `Done` every cycle. `Busy` is never asserted.
- MUL (iterative): `Busy` = 1 after E0. Iterations occur at E1..E16 (WIDTH edges). After E16: `Busy` = 0, `Done` = 1, `Result` valid. Latency is WIDTH+1 edges.
- The cycle in which `Done` is high for a MUL is IDLE; a `Start` sampled there (at E17) is accepted.
- `Reset` mid-MUL: abort at that edge. Next cycle shows the reset values; no `Done` is produced for the aborted operation.
- `Reset` and `Start` in the same cycle: `Reset` wins and `Start` is dropped.

## Configuration
- `ALU_EXEC_FAST_MUL_EN`
  - Defined: MUL is a single-cycle combinational product, truncated to WIDTH, with the same timing as the other ops. `Busy` is tied 0 and the MUL state and counter are not built.
  - Undefined: iterative MUL as specified above.

## Test plan
- ADD: A = 0x7FFF, B = 0x0001, Start at E0 -> after E0 `Result` = 0x8000, `Zero` = 0, `Done` = 1 for exactly one cycle.
- SUB then XOR back-to-back:
  - SUB, A = 0x0005, B = 0x0005 -> `Result` = 0x0000, `Zero` = 1.
  - XOR next cycle, A = 0xF0F0, B = 0x0FF0 -> `Result` = 0xFF00; `Done` stays high two cycles.
- Shifts:
  - ROR, A = 0x0001, B = 0x0001 -> 0x8000.
  - SLL, A = 0x0003, B = 0x0004 -> 0x0030.
  - ROR, A = 0xABCD, B = 0x0010 (amount 0) -> 0xABCD.
- MUL (macro undefined):
  - A = 0x0012, B = 0x0034 -> `Busy` high E1..E16, `Done` after E16, `Result` = 0x03A8.
  - A = 0x1234, B = 0x0100 -> 0x3400.
  - `Start` (AND) issued at E5 is ignored.
- Reset during MUL: assert `Reset` at E5 -> `Busy` = 0, `Result` = 0, `Zero` = 1, and no `Done` is seen through E20.
- `ALU_EXEC_FAST_MUL_EN` defined: MUL, A = 0x0012, B = 0x0034 -> `Result` = 0x03A8 and `Done` after E0, `Busy` never 1.
